amba_axi4_lite_slave_regfile: RTL and testbench
===============================================

Name: amba_axi4_lite_slave_regfile

Overview:
- AXI4-Lite responder (destination side) backed by a flat register file of NUM_REGS words.
- It is the DUT that the team's AXI4 protocol checker binds to with TYPE=1 (dest).
- It serves one outstanding write and one outstanding read.
- Out-of-range accesses complete with DECERR and never hang the bus.

Parameters:
- ADDRESS_WIDTH, 32, width of AWADDR/ARADDR.
- DATA_WIDTH, 32, data width; must be 32 or 64. Byte lanes NB = DATA_WIDTH/8. ADDR_LSB = log2(NB).
- NUM_REGS, 16, number of DATA_WIDTH registers. Power of two, 2..256.

Ports:
- ACLK  in  1  clock; all state changes on the rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- AWADDR  in  ADDRESS_WIDTH  write byte address.
- AWPROT  in  3  accepted, ignored.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- WDATA  in  DATA_WIDTH  write data.
- WSTRB  in  NB  byte-lane enables.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- BRESP  out  2  responses_t: OKAY or DECERR only.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- ARADDR  in  ADDRESS_WIDTH  read byte address.
- ARPROT  in  3  accepted, ignored.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  OKAY or DECERR.

Behaviour:
- Reset (async assert, sync release): aw_held=0, w_held=0, BVALID=0, RVALID=0, BRESP=OKAY, RRESP=OKAY, RDATA=0, all registers=0. Consequently AWREADY=1, WREADY=1, ARREADY=1 during and after reset.
- Reset mid-transaction drops every pending handshake. No response is issued for it.
- Address decode:
  - idx = addr[ADDR_LSB +: log2(NUM_REGS)].
  - In range iff addr < NUM_REGS*NB.
  - Low ADDR_LSB bits are ignored, so unaligned addresses are treated as aligned.
- Write address channel:
  - AWREADY = !aw_held (registered-state decode, no combinational path from inputs).
  - AW handshake captures AWADDR and sets aw_held.
- Write data channel:
  - WREADY = !w_held.
  - W handshake captures WDATA/WSTRB and sets w_held.
  - AW and W are independent; either may arrive first or in the same cycle.
- Write commit:
  - Condition at an edge: aw_held && w_held && (!BVALID || BREADY).
  - On commit: if in range, update byte k of reg[idx] iff WSTRB[k]=1. Clear both holds. BVALID<=1. BRESP<=OKAY (in range) or DECERR (out of range, no register changes).
- Latency: AW+W handshake at edge T gives commit at T+1, so BVALID is visible in the cycle after T+1.
- B channel:
  - BVALID and BRESP are held stable until BREADY.
  - B handshake with no new commit clears BVALID.
  - B handshake coinciding with a new commit keeps BVALID=1 with the new BRESP.
- Read channel:
  - ARREADY = !RVALID.
  - AR handshake at edge T sets RVALID<=1 and loads RDATA/RRESP: reg[idx]/OKAY if in range, else 0/DECERR.
  - RVALID, RDATA and RRESP are held stable until RREADY. R handshake clears RVALID.
  - Maximum rate is one read every 2 cycles.
- Read-during-write: if an AR handshake and a write commit hit the same edge and the same idx, RDATA returns the pre-write value.
- Responder never asserts VALID without a prior address handshake. No combinational VALID-to-READY dependency, so the block is compliant with the protocol checker's dest-side assertions.

Test Plan:
- Reset, then AW(0x4)+W(0xDEADBEEF, WSTRB=all ones) in the same cycle, BREADY=1 → BVALID one cycle after commit, BRESP=OKAY. Then AR(0x4) → RVALID next cycle, RDATA=0xDEADBEEF, RRESP=OKAY.
- W first (0x11223344, WSTRB=0b0101), AW(0x8) three cycles later, reg[2] previously 0xAAAAAAAA → reg[2]=0xAA22AA44. WREADY=0 while W is held alone.
- Out-of-range AW/AR at 0x40 with NUM_REGS=16 → BRESP=DECERR, RRESP=DECERR, RDATA=0, no register modified.
- BREADY=0 for 5 cycles after a write → BVALID and BRESP stable, AWREADY=0 and WREADY=0 once both holds are set again, no second commit. BREADY=1 → next write commits on the same edge as the B handshake.
- Read/write collision at reg[3]=0x5 with a commit of 0x9 → RDATA=0x5, a subsequent read returns 0x9.
- ARESET pulsed while RVALID=1 and aw_held=1 → all VALIDs 0 immediately, registers 0, READYs 1 after release.

Source files
------------

// File: rtl/amba_axi4_lite_slave_regfile.sv
// rtl/amba_axi4_lite_slave_regfile.sv - AXI4-Lite responder backed by a flat register file
module amba_axi4_lite_slave_regfile #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_REGS      = 16
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      AWVALID,
    output logic                      AWREADY,
    input  logic [ADDRESS_WIDTH-1:0]  AWADDR,
    input  logic [2:0]                AWPROT,
    input  logic                      WVALID,
    output logic                      WREADY,
    input  logic [DATA_WIDTH-1:0]     WDATA,
    input  logic [DATA_WIDTH/8-1:0]   WSTRB,
    output logic                      BVALID,
    input  logic                      BREADY,
    output logic [1:0]                BRESP,
    input  logic                      ARVALID,
    output logic                      ARREADY,
    input  logic [ADDRESS_WIDTH-1:0]  ARADDR,
    input  logic [2:0]                ARPROT,
    output logic                      RVALID,
    input  logic                      RREADY,
    output logic [DATA_WIDTH-1:0]     RDATA,
    output logic [1:0]                RRESP
);

    localparam int NB       = DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam logic [ADDRESS_WIDTH-1:0] LP_SPAN = ADDRESS_WIDTH'(NUM_REGS * NB);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Held write address: only the decoded index and range flag are needed later.
    logic                   r_aw_held;
    logic                   r_aw_in_range;
    logic [IDX_W-1:0]       r_aw_idx;
    logic                   r_w_held;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [NB-1:0]          r_wstrb;
    logic                   r_bvalid;
    logic [1:0]             r_bresp;
    logic                   r_rvalid;
    logic [DATA_WIDTH-1:0]  r_rdata;
    logic [1:0]             r_rresp;
    logic [DATA_WIDTH-1:0]  r_regs [NUM_REGS];

    logic                   w_aw_hs;
    logic                   w_w_hs;
    logic                   w_ar_hs;
    logic                   w_commit;
    logic                   w_aw_in_range;
    logic                   w_ar_in_range;
    logic [IDX_W-1:0]       w_aw_idx;
    logic [IDX_W-1:0]       w_ar_idx;
    logic                   w_unused_prot;

    // Protection bits are accepted but carry no meaning for this register file.
    assign w_unused_prot = ^{AWPROT, ARPROT};

    // READYs depend only on registered state, never on the incoming VALIDs.
    assign AWREADY = !r_aw_held;
    assign WREADY  = !r_w_held;
    assign ARREADY = !r_rvalid;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;

    assign w_aw_hs       = AWVALID && !r_aw_held;
    assign w_w_hs        = WVALID && !r_w_held;
    assign w_ar_hs       = ARVALID && !r_rvalid;
    // A commit needs both halves of the write and a free (or draining) B slot.
    assign w_commit      = r_aw_held && r_w_held && (!r_bvalid || BREADY);
    assign w_aw_in_range = AWADDR < LP_SPAN;
    assign w_ar_in_range = ARADDR < LP_SPAN;
    assign w_aw_idx      = AWADDR[ADDR_LSB +: IDX_W];
    assign w_ar_idx      = ARADDR[ADDR_LSB +: IDX_W];

    // Capture the write address and hold it until the write commits.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_aw_held     <= 1'b0;
            r_aw_in_range <= 1'b0;
            r_aw_idx      <= '0;
        end else if (w_commit) begin
            r_aw_held <= 1'b0;
        end else if (w_aw_hs) begin
            r_aw_held     <= 1'b1;
            r_aw_in_range <= w_aw_in_range;
            r_aw_idx      <= w_aw_idx;
        end
    end

    // Capture write data and strobes independently of the address channel.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_w_held <= 1'b0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
        end else if (w_commit) begin
            r_w_held <= 1'b0;
        end else if (w_w_hs) begin
            r_w_held <= 1'b1;
            r_wdata  <= WDATA;
            r_wstrb  <= WSTRB;
        end
    end

    // Write response: a commit coinciding with a B handshake reloads BVALID/BRESP.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
        end else if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= r_aw_in_range ? RESP_OKAY : RESP_DECERR;
        end else if (r_bvalid && BREADY) begin
            r_bvalid <= 1'b0;
        end
    end

    // Register file update with per-byte strobes; out-of-range commits leave it untouched.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && r_aw_in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (r_wstrb[k]) begin
                    r_regs[r_aw_idx][8*k +: 8] <= r_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read response: sampling r_regs before the same-edge write yields the pre-write value.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_in_range ? r_regs[w_ar_idx] : '0;
            r_rresp  <= w_ar_in_range ? RESP_OKAY : RESP_DECERR;
        end else if (r_rvalid && RREADY) begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_amba_axi4_lite_slave_regfile.sv
// tb/tb_amba_axi4_lite_slave_regfile.sv - scoreboard bench for the AXI4-Lite register file
module tb_amba_axi4_lite_slave_regfile;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] DECERR = 2'b11;

    logic        clk;
    logic        ARESET;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];
    logic [31:0] mdl [16];

    amba_axi4_lite_slave_regfile #(
        .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)
    ) dut (
        .ACLK(clk), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responses are compared on the falling edge preceding the handshake edge.
    always @(negedge clk) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                chk("b_expected", exp_b.size() != 0, 1);
                if (exp_b.size() != 0) chk("bresp", BRESP, exp_b.pop_front());
            end
            if (RVALID && RREADY) begin
                chk("r_expected", exp_r.size() != 0, 1);
                if (exp_r.size() != 0) begin
                    logic [33:0] e;
                    e = exp_r.pop_front();
                    chk("rdata", RDATA, e[33:2]);
                    chk("rresp", RRESP, e[1:0]);
                end
            end
        end
    end

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d,
                                        input logic [3:0] s);
        if (a < 32'h40) begin
            for (int k = 0; k < 4; k++)
                if (s[k]) mdl[a[5:2]][8*k +: 8] = d[8*k +: 8];
            exp_b.push_back(OKAY);
        end else begin
            exp_b.push_back(DECERR);
        end
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic aw_ok, w_ok;
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        model_write(a, d, s);
        for (int i = 0; i < 50 && (AWVALID || WVALID); i++) begin
            aw_ok = AWREADY;
            w_ok  = WREADY;
            tick();
            if (aw_ok) AWVALID = 1'b0;
            if (w_ok)  WVALID  = 1'b0;
        end
        if (AWVALID || WVALID) begin
            chk("write_timeout", 0, 1);
            AWVALID = 1'b0; WVALID = 1'b0;
        end
    endtask

    task automatic do_read(input logic [31:0] a);
        logic ar_ok;
        ARADDR = a; ARVALID = 1'b1;
        if (a < 32'h40) exp_r.push_back({mdl[a[5:2]], OKAY});
        else            exp_r.push_back({32'h0, DECERR});
        for (int i = 0; i < 50 && ARVALID; i++) begin
            ar_ok = ARREADY;
            tick();
            if (ar_ok) ARVALID = 1'b0;
        end
        if (ARVALID) begin
            chk("read_timeout", 0, 1);
            ARVALID = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (exp_b.size() != 0 || exp_r.size() != 0); i++) tick();
        chk("drain", exp_b.size() + exp_r.size(), 0);
    endtask

    initial begin
        logic [31:0] pre;
        ARESET = 1'b1;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = 0; ARADDR = 0; WDATA = 0; WSTRB = 0; AWPROT = 3'b010; ARPROT = 3'b001;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick(); tick();
        chk("rst_awready", AWREADY, 1);
        chk("rst_wready", WREADY, 1);
        chk("rst_arready", ARREADY, 1);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_rvalid", RVALID, 0);
        chk("rst_bresp", BRESP, OKAY);
        chk("rst_rresp", RRESP, OKAY);
        chk("rst_rdata", RDATA, 0);
        ARESET = 1'b0;
        tick();

        // Simultaneous AW+W, BVALID appears one cycle after the commit edge
        do_write(32'h4, 32'hDEADBEEF, 4'hF);
        chk("b_latency_early", BVALID, 0);
        tick();
        chk("b_latency_valid", BVALID, 1);
        tick();
        chk("b_cleared", BVALID, 0);
        do_read(32'h4);
        chk("r_latency_valid", RVALID, 1);
        drain();

        // W arrives alone, AW three cycles later, partial strobes
        do_write(32'h8, 32'hAAAAAAAA, 4'hF);
        drain();
        WDATA = 32'h11223344; WSTRB = 4'b0101; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("w_held_wready0", WREADY, 0);
        tick();
        chk("w_held_wready1", WREADY, 0);
        chk("w_alone_no_b", BVALID, 0);
        tick();
        chk("w_held_wready2", WREADY, 0);
        AWADDR = 32'h8; AWVALID = 1'b1;
        model_write(32'h8, 32'h11223344, 4'b0101);
        tick();
        AWVALID = 1'b0;
        drain();
        do_read(32'h8);
        drain();

        // Out-of-range and unaligned accesses
        do_write(32'h40, 32'hFFFFFFFF, 4'hF);
        do_read(32'h40);
        drain();
        do_read(32'h0);
        do_read(32'h7);
        do_read(32'hFFFFFFFC);
        drain();

        // Back-pressure on B, then a commit on the same edge as the B handshake
        BREADY = 1'b0;
        do_write(32'hC, 32'h12345678, 4'hF);
        tick();
        do_write(32'h44, 32'h0BADF00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            chk("bp_bvalid", BVALID, 1);
            chk("bp_bresp", BRESP, OKAY);
            chk("bp_awready", AWREADY, 0);
            chk("bp_wready", WREADY, 0);
            tick();
        end
        BREADY = 1'b1;
        tick();
        chk("bp_merge_bvalid", BVALID, 1);
        chk("bp_merge_bresp", BRESP, DECERR);
        chk("bp_merge_awready", AWREADY, 1);
        tick();
        chk("bp_done_bvalid", BVALID, 0);
        drain();

        // AR on the commit edge of a write to the same register
        do_write(32'hC, 32'h5, 4'hF);
        drain();
        pre = mdl[3];
        do_write(32'hC, 32'h9, 4'hF);
        ARADDR = 32'hC; ARVALID = 1'b1;
        exp_r.push_back({pre, OKAY});
        chk("coll_arready", ARREADY, 1);
        tick();
        ARVALID = 1'b0;
        drain();
        do_read(32'hC);
        drain();

        // Reset while a read response is pending and an address is held
        RREADY = 1'b0;
        do_read(32'h4);
        AWADDR = 32'h10; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        chk("pre_rst_rvalid", RVALID, 1);
        chk("pre_rst_awready", AWREADY, 0);
        ARESET = 1'b1;
        #1;
        chk("async_rst_rvalid", RVALID, 0);
        chk("async_rst_bvalid", BVALID, 0);
        chk("async_rst_awready", AWREADY, 1);
        exp_r.delete();
        exp_b.delete();
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        tick(); tick();
        ARESET = 1'b0;
        RREADY = 1'b1;
        tick();
        chk("post_rst_arready", ARREADY, 1);
        chk("post_rst_wready", WREADY, 1);
        chk("post_rst_bvalid", BVALID, 0);
        do_read(32'h4);
        do_read(32'h8);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
